// File: rtl/soml_fx_pkg.sv
// Shared fixed-point helpers, FSM state type and pipeline depth for the SOML
// channel-norm path.
package soml_fx_pkg;

    localparam int MAG2_LAT = 3;

    typedef enum logic [1:0] {
        ACC   = 2'd0,
        DRAIN = 2'd1,
        OUT   = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    // Largest positive value of a signed w-bit word: 2^(w-1)-1.
    function automatic longint fx_max(input int w);
        return (longint'(1) << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/cplx_mag2.sv
// Three-stage |h|^2 pipeline: register, square with Q-scaling, sum.
// Square saturation is enabled by HQ_NORM_SAT_EN; default build wraps.
module cplx_mag2
    import soml_fx_pkg::*;
#(
    parameter int W = 16,
    parameter int Q = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    output logic         out_valid,
    output logic [W:0]   out_sum,
    output logic         out_ovf
);

    localparam int W2 = 2 * W;
    localparam logic [W-1:0] SQ_MAX = W'(fx_max(W));

    logic signed [W-1:0]  re_q, im_q;
    logic                 v1_q, v2_q, v3_q;
    logic signed [W2-1:0] p_re, p_im;
    logic [W2-1:0]        sh_re, sh_im;
    logic                 ovf_re, ovf_im;
    logic [W-1:0]         sq_re_d, sq_im_d, sq_re_q, sq_im_q;
    logic                 ovf2_q, ovf3_q;
    logic [W:0]           sum_q;

    always_comb begin
        p_re   = W2'(re_q) * W2'(re_q);
        p_im   = W2'(im_q) * W2'(im_q);
        // Squares are never negative, so a logical shift truncates toward zero.
        sh_re  = $unsigned(p_re) >> Q;
        sh_im  = $unsigned(p_im) >> Q;
        ovf_re = |sh_re[W2-1:W-1];
        ovf_im = |sh_im[W2-1:W-1];
`ifdef HQ_NORM_SAT_EN
        sq_re_d = ovf_re ? SQ_MAX : sh_re[W-1:0];
        sq_im_d = ovf_im ? SQ_MAX : sh_im[W-1:0];
`else
        sq_re_d = sh_re[W-1:0];
        sq_im_d = sh_im[W-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            re_q    <= '0;
            im_q    <= '0;
            sq_re_q <= '0;
            sq_im_q <= '0;
            ovf2_q  <= 1'b0;
            sum_q   <= '0;
            ovf3_q  <= 1'b0;
        end else begin
            v1_q    <= in_valid;
            v2_q    <= v1_q;
            v3_q    <= v2_q;
            re_q    <= in_re;
            im_q    <= in_im;
            sq_re_q <= sq_re_d;
            sq_im_q <= sq_im_d;
            ovf2_q  <= ovf_re | ovf_im;
            sum_q   <= {1'b0, sq_re_q} + {1'b0, sq_im_q};
            ovf3_q  <= ovf2_q;
        end
    end

    assign out_valid = v3_q;
    assign out_sum   = sum_q;
    assign out_ovf   = ovf3_q;

endmodule

// File: rtl/hq_norm_acc.sv
// Streaming channel-norm accumulator: sums LEN |h|^2 samples into one D_h result.
// Define HQ_NORM_SAT_EN to clamp overflowed squares and the output norm.
module hq_norm_acc
    import soml_fx_pkg::*;
#(
    parameter int W   = 16,
    parameter int Q   = 8,
    parameter int LEN = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_re,
    input  logic [W-1:0] in_im,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_norm,
    output logic         out_ovf,
    output logic         busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and out_norm/out_ovf hold while out_valid waits.

    localparam int CNT_W = (clog2(LEN) < 1) ? 1 : clog2(LEN);
    localparam int ACC_W = W + clog2(LEN) + 1;
    localparam logic [ACC_W-1:0] ACC_MAX    = ACC_W'(fx_max(W));
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(LEN - 1);
    localparam logic [1:0]       DRAIN_LAST = 2'(MAG2_LAT - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [1:0]       drain_q;
    logic [ACC_W-1:0] acc_q, acc_sum;
    logic             ovf_q;
    logic             in_fire, out_fire;
    logic             mag_valid, mag_ovf;
    logic [W:0]       mag_sum;

    cplx_mag2 #(.W(W), .Q(Q)) u_mag2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_fire),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (mag_valid),
        .out_sum   (mag_sum),
        .out_ovf   (mag_ovf)
    );

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            ACC: begin
                in_ready = 1'b1;
                if (in_valid && cnt_q == CNT_LAST) state_d = DRAIN;
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) state_d = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_d = ACC;
            end
            default: state_d = ACC;
        endcase
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign acc_sum  = acc_q + ACC_W'(mag_sum);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACC;
            cnt_q   <= '0;
            drain_q <= '0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (in_fire) cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            drain_q <= (state_q == DRAIN) ? drain_q + 2'd1 : 2'd0;
            // The pipeline is empty in OUT, so clearing never races a pending sample.
            if (out_fire) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else if (mag_valid) begin
                acc_q <= acc_sum;
                if (mag_ovf || acc_sum > ACC_MAX) ovf_q <= 1'b1;
            end
        end
    end

`ifdef HQ_NORM_SAT_EN
    assign out_norm = (acc_q > ACC_MAX) ? ACC_MAX[W-1:0] : acc_q[W-1:0];
`else
    assign out_norm = acc_q[W-1:0];
`endif
    assign out_ovf = ovf_q;
    assign busy    = (state_q != ACC) || (cnt_q != '0);

endmodule

// File: doc/hq_norm_acc.md
Name: hq_norm_acc

Overview:
- Streaming channel-norm engine for the SOML decoder.
- Accepts complex channel coefficients (re/im, signed fixed-point Q format) over a valid/ready handshake and computes |h|^2 = re^2 + im^2 per sample through a pipeline.
- Accumulates LEN samples into one D_h norm and presents it on a held valid/ready output.
- Successor of the fixed 16-bit/8-entry D_h path: generalised in width, Q point and group length, with backpressure and overflow reporting.

Parameters:
- W, 16, data width of re/im inputs and of out_norm (signed two's complement).
- Q, 8, fractional bits of the fixed-point format (1.0 = 2^Q).
- LEN, 8, samples per accumulation group; legal range 2..256.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample this cycle.
- in_re  in  W  real part, signed QW.Q.
- in_im  in  W  imaginary part, signed QW.Q.
- out_valid  out  1  group result available.
- out_ready  in  1  consumer takes the result.
- out_norm  out  W  accumulated norm, signed Q format, always >= 0.
- out_ovf  out  1  overflow occurred somewhere in this group.
- busy  out  1  state != ACC or sample count != 0.

Behaviour:
- Reset: rst is sampled on the clk rising edge.
  - State = ACC, sample counter = 0, accumulator = 0, ovf flag = 0.
  - All pipeline valids = 0.
  - Outputs: out_valid=0, out_norm=0, out_ovf=0, in_ready=1, busy=0.
- Reset mid-group or mid-output discards all partial data. No result is emitted for that group.
- Accept: a sample is taken on any edge with in_valid && in_ready.
- Pipeline, for a sample accepted at edge t:
  - Stage 1 (edge t): register re, im.
  - Stage 2 (edge t+1): register sq_re = (re*re) >> Q and sq_im = (im*im) >> Q.
    - Products are full 2W-bit signed, truncated toward zero (non-negative, so a plain shift).
    - A square overflows if the shifted value > 2^(W-1)-1. This includes re = -2^(W-1).
  - Stage 3 (edge t+2): register s = sq_re + sq_im, W+1 bits unsigned.
  - Edge t+3: acc <= acc + s. The accumulator is W+clog2(LEN)+1 bits internally.
- Group overflow: the group ovf flag sets if any square overflowed, or if acc exceeds 2^(W-1)-1.
- FSM states and transitions:
  - ACC: in_ready=1. The counter increments per accepted sample. On the LEN-th acceptance (counter==LEN-1), counter <= 0 and go to DRAIN.
  - DRAIN: in_ready=0. Wait exactly 3 cycles for the pipeline to flush, then go to OUT.
  - OUT: out_valid=1. out_norm and out_ovf are held stable. On out_valid && out_ready, clear acc and the ovf flag and go to ACC.
- Latency: out_valid rises at edge t+3, where t is the edge accepting the LEN-th sample. out_ready high at edge t+3 completes the transfer after 1 cycle.
- Throughput: LEN+4 cycles per group minimum.
- Bubbles: in_valid gaps inside a group are allowed; the counter counts accepted samples only.
- out_ready outside OUT is ignored.
- in_valid outside ACC is ignored. Data is not captured, and the source must hold it.
- out_norm output: the low W bits of acc, or saturated (see Optional Feature). out_ovf = group ovf flag.

Optional Feature:
- Macro: HQ_NORM_SAT_EN.
- Defined:
  - Each overflowed square clamps to 2^(W-1)-1 before the sum.
  - out_norm clamps to 2^(W-1)-1 when acc > 2^(W-1)-1.
- Undefined:
  - Squares and out_norm are truncated to their low bits and wrap.
- out_ovf is reported identically in both builds.

Decomposition:
- Package soml_fx_pkg:
  - function/localparam for clog2;
  - fixed-point max constant FX_MAX(W) = 2^(W-1)-1;
  - FSM state enum {ACC, DRAIN, OUT};
  - pipeline depth constant MAG2_LAT = 3.
- Sub-module cplx_mag2:
  - stages 1-3 (register, square, sum), with a valid pipe and per-sample overflow bit;
  - parametrised by W and Q.
- hq_norm_acc holds the FSM, counter, accumulator and output register.

Test Plan:
- W=16, Q=8, LEN=8, 8 samples re=0x0100, im=0x0000 back-to-back -> out_norm=0x0800 (8.0), out_ovf=0; out_valid 3 cycles after the 8th accept.
- 8 samples re=0xFF00 (-1.0), im=0xFE00 (-2.0), random in_valid gaps -> out_norm=0x2800 (40.0), out_ovf=0.
- 8 samples re=0x0C00 (12.0), im=0 -> out_ovf=1; SAT_EN build: out_norm=0x7FFF; no-SAT build: low 16 bits of the wrapped sum.
- Result ready, out_ready held low 5 cycles -> out_valid stays 1, out_norm stable, in_ready=0 throughout; result accepted on the 6th cycle, in_ready returns 1 the next cycle.
- 3 samples accepted, then rst for 1 cycle, then 8 samples re=im=0x0080 (0.5) -> no output for the aborted group; next out_norm=0x0400 (4.0).
- LEN=4: two groups back-to-back with out_ready tied high -> two results, second group starts 1 cycle after the first transfer.
